// File: rtl/ifetch.sv
// ifetch: instruction fetch stage; one outstanding imem request, in-order FIFO of {pc, word} to decode.
// Latency: imem_req at t, imem_ack at t+k, inst_valid at t+k+1 (t+k with IFETCH_BYPASS_EN on an empty buffer).
// Backpressure: stall holds the head; requests are issued only while the buffer has a free entry.
// Optional macro IFETCH_BYPASS_EN: present an acknowledged word in its arrival cycle when the buffer is empty.

// ifetch_fifo: small circular buffer with synchronous flush.
// Latency: push visible at head the cycle after the write.
// Backpressure: the writer must not push while full; pop on an empty buffer is ignored.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointer/count update; flush wins over any push or pop in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_vld && !flush;
        do_pop   = pop_rdy && (cnt_q != '0) && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;

    // The fetch FSM only requests with a free slot and one request in flight, so this never fires.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && !flush && (cnt_q == DEPTH_CNT)))
        else $error("ifetch_fifo: push while full");
endmodule

module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] inst_word,
    output logic        inst_valid
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;

    logic          push_vld;
    logic          pop_rdy;
    logic          fifo_vld;
    logic          bypass_hit;
    logic [63:0]   head_dat;
    logic [CW-1:0] fifo_cnt;
    logic [1:0]    unused_redirect_lsb;

    // Low address bits of a redirect target are forced to zero, so they are never read.
    assign unused_redirect_lsb = redirect_pc[1:0];

    assign fifo_vld = (fifo_cnt != '0);
    assign pop_rdy  = fifo_vld && !stall && !redirect;

`ifdef IFETCH_BYPASS_EN
    // A response landing on an empty buffer can go straight to decode.
    assign bypass_hit = (state_q == S_WAIT) && imem_ack && !redirect && !fifo_vld;
`else
    assign bypass_hit = 1'b0;
`endif

    // Fetch FSM: request issue, response capture and redirect handling.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        push_vld    = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // A request still in flight must have its response swallowed.
            if ((state_q == S_WAIT || state_q == S_DROP) && !imem_ack) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fifo_cnt < DEPTH_CNT) begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = fetch_pc_q;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        // A bypassed word consumed by decode this cycle is not buffered.
                        push_vld   = !(bypass_hit && !stall);
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Fetch FSM and request registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    ifetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst_n    (reset_n),
        .flush    (redirect),
        .push_vld (push_vld),
        .push_dat ({imem_addr_q, imem_rdata}),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .cnt      (fifo_cnt)
    );

    // Decode-facing outputs: buffer head, else bypassed response, else idle nop at fetch_pc.
    always_comb begin
        inst_valid = fifo_vld;
        pc         = fetch_pc_q;
        inst_word  = 32'h0;
        if (fifo_vld) begin
            pc        = head_dat[63:32];
            inst_word = head_dat[31:0];
        end else if (bypass_hit) begin
            inst_valid = 1'b1;
            pc         = imem_addr_q;
            inst_word  = imem_rdata;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, streaming, stall, redirects, wrap, reset mid-fetch.
// Memory responder answers each request after mem_lat cycles with addr ^ 32'h1357_9BDF.
// All timing is checked at negedges against hand-derived cycle offsets.
module tb_ifetch;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef IFETCH_BYPASS_EN
    localparam int VLD_LAT = 0;
`else
    localparam int VLD_LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst_word;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    bit mem_en   = 1'b1;

    ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .inst_word   (inst_word),
        .inst_valid  (inst_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: one ack pulse mem_lat cycles after each seen request.
    initial begin : responder
        logic [31:0] req_addr;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clock); #1;
            if (mem_en && reset_n && imem_req) begin
                req_addr = imem_addr;
                repeat (mem_lat) @(posedge clock);
                #1;
                imem_ack   = 1'b1;
                imem_rdata = mem_word(req_addr);
                @(posedge clock); #1;
                imem_ack   = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (imem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RST_PC); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_word !== 32'h0) begin n_fail++; $display("FAIL rst_word: got %h expected 0", inst_word); end
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pc, RST_PC); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    // Ack latency 1: request every 3 cycles, word valid 1+VLD_LAT cycles after its request.
    task automatic test_stream();
        bit found;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = RST_PC + 32'(4 * i);
            if (i == 0) begin
                wait_req(found);
                n_checks++; if (!found) begin n_fail++; $display("FAIL stream_first_req: got timeout expected imem_req"); end
            end else begin
                @(negedge clock);
            end
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %b expected 1", i, imem_req); end
            n_checks++; if (imem_addr !== a) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, a); end
            repeat (1 + VLD_LAT) @(negedge clock);
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, inst_valid); end
            n_checks++; if (pc !== a) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pc, a); end
            n_checks++; if (inst_word !== mem_word(a)) begin n_fail++; $display("FAIL stream_word[%0d]: got %h expected %h", i, inst_word, mem_word(a)); end
            repeat (1 - VLD_LAT) @(negedge clock);
        end
    endtask

    // Stall from the next request: buffer fills to 2, requests stop, head held; release drains in order.
    task automatic test_stall();
        logic [31:0] n;
        n = RST_PC + 32'h10;
        @(posedge clock); #1;
        stall = 1'b1;
        @(negedge clock);
        n_checks++; if (imem_addr !== n) begin n_fail++; $display("FAIL stall_first_addr: got %h expected %h", imem_addr, n); end
        repeat (5) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, inst_valid); end
            n_checks++; if (pc !== n) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, n); end
            n_checks++; if (inst_word !== mem_word(n)) begin n_fail++; $display("FAIL stall_word[%0d]: got %h expected %h", i, inst_word, mem_word(n)); end
            if (i < 2) @(negedge clock);
        end
        @(posedge clock); #1;
        stall = 1'b0;
        @(negedge clock);
        n_checks++; if (pc !== n) begin n_fail++; $display("FAIL drain_pc0: got %h expected %h", pc, n); end
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid1: got %b expected 1", inst_valid); end
        n_checks++; if (pc !== n + 32'd4) begin n_fail++; $display("FAIL drain_pc1: got %h expected %h", pc, n + 32'd4); end
        n_checks++; if (inst_word !== mem_word(n + 32'd4)) begin n_fail++; $display("FAIL drain_word1: got %h expected %h", inst_word, mem_word(n + 32'd4)); end
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== n + 32'd8) begin n_fail++; $display("FAIL drain_next_req: got %b/%h expected 1/%h", imem_req, imem_addr, n + 32'd8); end
        repeat (1 + VLD_LAT) @(negedge clock);
        n_checks++; if (pc !== n + 32'd8 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL drain_pc2: got %h/%b expected %h/1", pc, inst_valid, n + 32'd8); end
        repeat (1 - VLD_LAT) @(negedge clock);
        mem_lat = 3;
    endtask

    // Redirect to an unaligned target while a 3-cycle request is outstanding.
    task automatic test_redirect_outstanding();
        logic [31:0] tgt;
        tgt = 32'h0040_0100;
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'h1C) begin n_fail++; $display("FAIL redir_pre_req: got %b/%h expected 1/%h", imem_req, imem_addr, RST_PC + 32'h1C); end
        @(posedge clock); #1;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0101;
        @(posedge clock); #1;
        redirect = 1'b0;
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_a: got %b expected 0", inst_valid); end
        n_checks++; if (pc !== tgt) begin n_fail++; $display("FAIL redir_empty_pc: got %h expected %h", pc, tgt); end
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_ack: got %b expected 0", inst_valid); end
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_gap: got valid %b req %b expected 0/0", inst_valid, imem_req); end
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== tgt) begin n_fail++; $display("FAIL redir_new_req: got %b/%h expected 1/%h", imem_req, imem_addr, tgt); end
        repeat (3 + VLD_LAT) @(negedge clock);
        n_checks++; if (inst_valid !== 1'b1 || pc !== tgt) begin n_fail++; $display("FAIL redir_first_pc: got %b/%h expected 1/%h", inst_valid, pc, tgt); end
        n_checks++; if (inst_word !== mem_word(tgt)) begin n_fail++; $display("FAIL redir_first_word: got %h expected %h", inst_word, mem_word(tgt)); end
        repeat (1 - VLD_LAT) @(negedge clock);
        mem_lat = 1;
    endtask

    // Redirect coincident with ack, target 0xFFFFFFFC, then wrap to 0.
    task automatic test_redirect_ack_wrap();
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0104) begin n_fail++; $display("FAIL rack_pre_req: got %b/%h expected 1/00400104", imem_req, imem_addr); end
        @(posedge clock); #1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clock); #1;
        redirect = 1'b0;
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rack_dropped: got req %b valid %b expected 0/0", imem_req, inst_valid); end
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rack_pc: got %h expected fffffffc", pc); end
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rack_req: got %b/%h expected 1/fffffffc", imem_req, imem_addr); end
        repeat (1 + VLD_LAT) @(negedge clock);
        n_checks++; if (pc !== 32'hFFFF_FFFC || inst_word !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rack_word: got %h/%h expected fffffffc/%h", pc, inst_word, mem_word(32'hFFFF_FFFC)); end
        repeat (2 - VLD_LAT) @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        repeat (1 + VLD_LAT) @(negedge clock);
        n_checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %b/%h expected 1/00000000", inst_valid, pc); end
        repeat (1 - VLD_LAT) @(negedge clock);
        mem_en = 1'b0;
    endtask

    // Reset while waiting on memory; a late ack after release must be ignored.
    task automatic test_reset_midflight();
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL mid_req: got %b/%h expected 1/00000004", imem_req, imem_addr); end
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL mid_rst_req: got %b/%h expected 0/%h", imem_req, imem_addr, RST_PC); end
        n_checks++; if (inst_valid !== 1'b0 || inst_word !== 32'h0 || pc !== RST_PC) begin n_fail++; $display("FAIL mid_rst_out: got %b/%h/%h expected 0/0/%h", inst_valid, inst_word, pc, RST_PC); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_out: got valid %b req %b expected 0/0", inst_valid, imem_req); end
        mem_en = 1'b1;
        @(posedge clock); #1;
        imem_ack = 1'b0;
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL post_rst_req: got %b/%h expected 1/%h", imem_req, imem_addr, RST_PC); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_ignored: got %b expected 0", inst_valid); end
        repeat (1 + VLD_LAT) @(negedge clock);
        n_checks++; if (inst_valid !== 1'b1 || pc !== RST_PC || inst_word !== mem_word(RST_PC)) begin n_fail++; $display("FAIL post_rst_word: got %b/%h/%h expected 1/%h/%h", inst_valid, pc, inst_word, RST_PC, mem_word(RST_PC)); end
    endtask

    initial begin : main
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_ack_wrap();
        test_reset_midflight();
        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
